ship_hit_ctrl: RTL and testbench

SHIP_HIT_CTRL -- requirements
Module: ship_hit_ctrl

---
 rtl/game_pkg.sv | 32 +++
 rtl/box_overlap.sv | 26 ++
 rtl/ship_hit_ctrl.sv | 115 +++++++++++
 tb/tb_ship_hit_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types: ship life-cycle states, game-state codes and the box
// descriptor used by every collision check.
package game_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    HIT    = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } ship_state_t;

  localparam logic [3:0] ST_TITLE = 4'd0;
  localparam logic [3:0] ST_PLAY  = 4'd1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] w;
    logic [9:0] h;
  } box_t;

  function automatic box_t mk_box(input logic [9:0] x, input logic [9:0] y,
                                  input logic [9:0] w, input logic [9:0] h);
    box_t b;
    b.x = x;
    b.y = y;
    b.w = w;
    b.h = h;
    return b;
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Axis-aligned box intersection, purely combinational; edges that merely touch
// do not count. Sums are 11 bits so boxes near the 1023 limit cannot wrap.
import game_pkg::*;

module box_overlap (
  input  box_t i_a,
  input  box_t i_b,
  output logic o_overlap
);

  logic [10:0] w_a_right;
  logic [10:0] w_b_right;
  logic [10:0] w_a_bottom;
  logic [10:0] w_b_bottom;

  assign w_a_right  = {1'b0, i_a.x} + {1'b0, i_a.w};
  assign w_b_right  = {1'b0, i_b.x} + {1'b0, i_b.w};
  assign w_a_bottom = {1'b0, i_a.y} + {1'b0, i_a.h};
  assign w_b_bottom = {1'b0, i_b.y} + {1'b0, i_b.h};

  assign o_overlap = (w_a_right  > {1'b0, i_b.x}) &&
                     (w_b_right  > {1'b0, i_a.x}) &&
                     (w_a_bottom > {1'b0, i_b.y}) &&
                     (w_b_bottom > {1'b0, i_a.y});

endmodule

// File: rtl/ship_hit_ctrl.sv
// Player ship hit handling: detects alien-missile hits, runs the explosion and
// respawn-grace timers, tracks lives. All state advances once per frame edge.
import game_pkg::*;

module ship_hit_ctrl #(
  parameter logic [9:0] SHIP_Y        = 10'd440,
  parameter logic [9:0] SHIP_W        = 10'd32,
  parameter logic [9:0] SHIP_H        = 10'd16,
  parameter logic [9:0] MISSILE_W     = 10'd4,
  parameter logic [9:0] MISSILE_H     = 10'd8,
  parameter logic [7:0] HIT_FRAMES    = 8'd60,
  parameter logic [7:0] INVULN_FRAMES = 8'd120,
  parameter logic [1:0] START_LIVES   = 2'd3
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [3:0] state,
  input  logic       exists,
  input  logic [9:0] missileX,
  input  logic [9:0] missileY,
  input  logic [9:0] ship_X,
  output logic       destroy,
  output logic [1:0] lives,
  output logic       hit_active,
  output logic       ship_visible,
  output logic       game_over
);

  ship_state_t r_fsm;
  ship_state_t w_fsm_nxt;
  logic [7:0]  r_timer;
  logic [7:0]  w_timer_nxt;
  logic [1:0]  r_lives;
  logic [1:0]  w_lives_nxt;
  logic        r_destroy;
  logic        w_destroy_nxt;
  logic        w_overlap;
  logic        w_hit;
  box_t        w_missile_box;
  box_t        w_ship_box;

  assign w_missile_box = mk_box(missileX, missileY, MISSILE_W, MISSILE_H);
  assign w_ship_box    = mk_box(ship_X, SHIP_Y, SHIP_W, SHIP_H);

  box_overlap u_overlap (
    .i_a       (w_missile_box),
    .i_b       (w_ship_box),
    .o_overlap (w_overlap)
  );

  assign w_hit = exists && w_overlap && (state == ST_PLAY) && (r_fsm == ALIVE);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_fsm     <= ALIVE;
      r_timer   <= 8'd0;
      r_lives   <= START_LIVES;
      r_destroy <= 1'b0;
    end else begin
      r_fsm     <= w_fsm_nxt;
      r_timer   <= w_timer_nxt;
      r_lives   <= w_lives_nxt;
      r_destroy <= w_destroy_nxt;
    end
  end

  // Title restarts everything; any game state other than play freezes the ship.
  always_comb begin
    w_fsm_nxt     = r_fsm;
    w_timer_nxt   = r_timer;
    w_lives_nxt   = r_lives;
    w_destroy_nxt = 1'b0;
    if (state == ST_TITLE) begin
      w_fsm_nxt   = ALIVE;
      w_timer_nxt = 8'd0;
      w_lives_nxt = START_LIVES;
    end else if (state == ST_PLAY) begin
      case (r_fsm)
        ALIVE: begin
          if (w_hit) begin
            w_destroy_nxt = 1'b1;
            w_fsm_nxt     = HIT;
            w_timer_nxt   = 8'd0;
            if (r_lives != 2'd0) w_lives_nxt = r_lives - 2'd1;
          end
        end
        HIT: begin
          if (r_timer == HIT_FRAMES - 8'd1) begin
            w_fsm_nxt   = (r_lives == 2'd0) ? DEAD : INVULN;
            w_timer_nxt = 8'd0;
          end else begin
            w_timer_nxt = r_timer + 8'd1;
          end
        end
        INVULN: begin
          if (r_timer == INVULN_FRAMES - 8'd1) begin
            w_fsm_nxt   = ALIVE;
            w_timer_nxt = 8'd0;
          end else begin
            w_timer_nxt = r_timer + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign destroy      = r_destroy;
  assign lives        = r_lives;
  assign hit_active   = (r_fsm == HIT);
  assign game_over    = (r_fsm == DEAD);
  assign ship_visible = (r_fsm == ALIVE) ? 1'b1 :
                        (r_fsm == INVULN) ? r_timer[3] : 1'b0;

endmodule

// File: tb/tb_ship_hit_ctrl.sv
// Frame-by-frame bench for ship_hit_ctrl: expected outputs are queued as each
// frame is driven and compared after the frame edge.
module tb_ship_hit_ctrl;

  typedef struct packed {
    logic       destroy;
    logic [1:0] lives;
    logic       hit_active;
    logic       ship_visible;
    logic       game_over;
  } obs_t;

  logic       frame_clk;
  logic       Reset;
  logic [3:0] state;
  logic       exists;
  logic [9:0] missileX;
  logic [9:0] missileY;
  logic [9:0] ship_X;
  logic       destroy;
  logic [1:0] lives;
  logic       hit_active;
  logic       ship_visible;
  logic       game_over;

  int   checks;
  int   errors;
  obs_t exp_q[$];
  obs_t got;
  obs_t want;

  ship_hit_ctrl dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .state        (state),
    .exists       (exists),
    .missileX     (missileX),
    .missileY     (missileY),
    .ship_X       (ship_X),
    .destroy      (destroy),
    .lives        (lives),
    .hit_active   (hit_active),
    .ship_visible (ship_visible),
    .game_over    (game_over)
  );

  assign got = '{destroy, lives, hit_active, ship_visible, game_over};

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "timeout");
  end

  // Expected outputs j frames after the frame that registered a hit:
  // 60 frames of explosion, then either DEAD or 120 frames of blinking grace.
  function automatic obs_t after_hit(input int j, input logic [1:0] lv, input logic dead);
    obs_t o;
    int   t;
    t = j - 60;
    if (j < 60)      o = '{(j == 0), lv, 1'b1, 1'b0, 1'b0};
    else if (dead)   o = '{1'b0, lv, 1'b0, 1'b0, 1'b1};
    else if (j < 180) o = '{1'b0, lv, 1'b0, t[3], 1'b0};
    else             o = '{1'b0, lv, 1'b0, 1'b1, 1'b0};
    return o;
  endfunction

  task automatic drive_frame(input logic [3:0] st, input logic ex,
                             input logic [9:0] mx, input logic [9:0] my);
    state    = st;
    exists   = ex;
    missileX = mx;
    missileY = my;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    state = 4'd0; exists = 1'b0; missileX = 10'd0; missileY = 10'd0; ship_X = 10'd100;
    repeat (2) @(posedge frame_clk);
    #1;
    exp_q.push_back('{1'b0, 2'd3, 1'b0, 1'b1, 1'b0});
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset: got %b expected %b", got, want);
    end
    Reset = 1'b0;
    drive_frame(4'd0, 1'b0, 10'd0, 10'd0);
  endtask

  task automatic test_frozen_no_hit;
    for (int j = 0; j < 7; j++) begin
      exp_q.push_back('{1'b0, 2'd3, 1'b0, 1'b1, 1'b0});
      if (j < 3)      drive_frame(4'd2, 1'b1, 10'd110, 10'd436);
      else if (j < 5) drive_frame(4'd5, 1'b1, 10'd110, 10'd436);
      else            drive_frame(4'd1, 1'b0, 10'd110, 10'd436);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL frozen_no_hit frame %0d: got %b expected %b", j, got, want);
      end
    end
  endtask

  task automatic test_hit_invuln;
    for (int j = 0; j < 183; j++) begin
      exp_q.push_back(after_hit(j, 2'd2, 1'b0));
      drive_frame(4'd1, (j <= 180), 10'd110, 10'd436);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL hit_invuln frame %0d: got %b expected %b", j, got, want);
      end
    end
  endtask

  task automatic test_edge;
    for (int j = 0; j < 3; j++) begin
      exp_q.push_back('{1'b0, 2'd2, 1'b0, 1'b1, 1'b0});
      drive_frame(4'd1, 1'b1, 10'd96, 10'd436);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL edge_touch frame %0d: got %b expected %b", j, got, want);
      end
    end
    for (int j = 0; j < 182; j++) begin
      exp_q.push_back(after_hit(j, 2'd1, 1'b0));
      drive_frame(4'd1, (j == 0), 10'd97, 10'd436);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL edge_hit frame %0d: got %b expected %b", j, got, want);
      end
    end
  endtask

  task automatic test_freeze_game_over;
    for (int j = 0; j < 20; j++) begin
      exp_q.push_back(after_hit(j, 2'd0, 1'b1));
      drive_frame(4'd1, 1'b1, 10'd110, 10'd436);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL last_hit frame %0d: got %b expected %b", j, got, want);
      end
    end
    for (int j = 0; j < 10; j++) begin
      exp_q.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 1'b0});
      drive_frame(4'd2, 1'b1, 10'd110, 10'd436);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL freeze frame %0d: got %b expected %b", j, got, want);
      end
    end
    for (int j = 20; j < 66; j++) begin
      exp_q.push_back(after_hit(j, 2'd0, 1'b1));
      drive_frame(4'd1, 1'b1, 10'd110, 10'd436);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL resume_dead frame %0d: got %b expected %b", j, got, want);
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (j < 3) exp_q.push_back('{1'b0, 2'd0, 1'b0, 1'b0, 1'b1});
      else       exp_q.push_back('{1'b0, 2'd3, 1'b0, 1'b1, 1'b0});
      drive_frame((j < 3) ? 4'd2 : 4'd0, 1'b1, 10'd110, 10'd436);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL game_over_restart frame %0d: got %b expected %b", j, got, want);
      end
    end
  endtask

  task automatic test_title_override;
    for (int j = 0; j < 8; j++) begin
      if (j < 5) exp_q.push_back(after_hit(j, 2'd2, 1'b0));
      else       exp_q.push_back('{1'b0, 2'd3, 1'b0, 1'b1, 1'b0});
      drive_frame((j < 5) ? 4'd1 : 4'd0, (j == 0), 10'd110, 10'd436);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL title_override frame %0d: got %b expected %b", j, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_hit;
    for (int j = 0; j < 20; j++) begin
      exp_q.push_back(after_hit(j, 2'd2, 1'b0));
      drive_frame(4'd1, (j == 0), 10'd110, 10'd436);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pre_reset frame %0d: got %b expected %b", j, got, want);
      end
    end
    Reset = 1'b1;
    #2;
    exp_q.push_back('{1'b0, 2'd3, 1'b0, 1'b1, 1'b0});
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_mid_hit: got %b expected %b", got, want);
    end
    @(negedge frame_clk);
    Reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      exp_q.push_back('{1'b0, 2'd3, 1'b0, 1'b1, 1'b0});
      drive_frame(4'd1, 1'b0, 10'd110, 10'd436);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL post_reset frame %0d: got %b expected %b", j, got, want);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_frozen_no_hit();
    test_hit_invuln();
    test_edge();
    test_freeze_game_over();
    test_title_override();
    test_reset_mid_hit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
